// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: steps the PC, runs one-at-a-time imem transactions, buffers the word for decode.
// Optional misaligned-target trapping is enabled by defining FETCH_CTRL_MISALIGN_EN.
module fetch_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [XLEN-1:0] pc,
    output logic            pc_pause,
    output logic [XLEN-1:0] pc_npc,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    input  logic            id_ready,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [31:0]     if_instr,
    output logic            fetch_fault
);

`ifdef FETCH_CTRL_MISALIGN_EN
    typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, FAULT} state_t;
`else
    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;
`endif

    state_t            state_q, state_d;
    logic [XLEN-1:0]   req_addr_q, req_addr_d;
    logic              kill_q, kill_d;
    logic              imem_req_q, imem_req_d;
    logic              if_valid_q, if_valid_d;
    logic [XLEN-1:0]   if_pc_q, if_pc_d;
    logic [31:0]       if_instr_q, if_instr_d;
    logic              start_fetch;
`ifdef FETCH_CTRL_MISALIGN_EN
    logic              fault_q, fault_d;
`endif

    // A redirect always wins; otherwise the PC only moves when a live fetch is accepted.
    always_comb begin
        pc_npc   = pc + XLEN'(4);
        pc_pause = 1'b1;
        if (redirect) begin
            pc_pause = 1'b0;
            pc_npc   = redirect_pc;
        end else if (state_q == REQ && imem_ack && !kill_q) begin
            pc_pause = 1'b0;
        end
    end

    always_comb begin
        // NOTE: every target gets a default before the case so no path can infer a latch.
        state_d     = state_q;
        req_addr_d  = req_addr_q;
        kill_d      = kill_q;
        if_valid_d  = if_valid_q;
        if_pc_d     = if_pc_q;
        if_instr_d  = if_instr_q;
        start_fetch = 1'b0;
`ifdef FETCH_CTRL_MISALIGN_EN
        fault_d     = fault_q;
`endif

        case (state_q)
            // A redirect here holds IDLE one cycle so the updated pc is the one sampled.
            IDLE: if (!redirect) start_fetch = 1'b1;
            REQ: begin
                if (redirect) kill_d = 1'b1;
                if (imem_ack) state_d = WAIT;
            end
            WAIT: begin
                if (imem_rvalid) begin
                    if (kill_q || redirect) begin
                        kill_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        if_instr_d = imem_rdata;
                        if_pc_d    = req_addr_q;
                        if_valid_d = 1'b1;
                        state_d    = HOLD;
                    end
                end else if (redirect) begin
                    kill_d = 1'b1;
                end
            end
            HOLD: begin
                if (redirect) begin
                    if_valid_d = 1'b0;
                    state_d    = IDLE;
                end else if (id_ready) begin
                    if_valid_d  = 1'b0;
                    start_fetch = 1'b1;
                end
            end
`ifdef FETCH_CTRL_MISALIGN_EN
            FAULT: begin
                if (redirect) begin
                    fault_d = 1'b0;
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        // Shared IDLE/HOLD exit: capture the PC and either launch the fetch or trap it.
        if (start_fetch) begin
            req_addr_d = pc;
`ifdef FETCH_CTRL_MISALIGN_EN
            if (pc[1:0] != 2'b00) begin
                fault_d = 1'b1;
                if_pc_d = pc;
                state_d = FAULT;
            end else begin
                state_d = REQ;
            end
`else
            state_d = REQ;
`endif
        end

        imem_req_d = (state_d == REQ);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            req_addr_q <= '0;
            kill_q     <= 1'b0;
            imem_req_q <= 1'b0;
            if_valid_q <= 1'b0;
            if_pc_q    <= '0;
            if_instr_q <= '0;
`ifdef FETCH_CTRL_MISALIGN_EN
            fault_q    <= 1'b0;
`endif
        end else begin
            // NOTE: state updates are non-blocking so every flop samples pre-edge values.
            state_q    <= state_d;
            req_addr_q <= req_addr_d;
            kill_q     <= kill_d;
            imem_req_q <= imem_req_d;
            if_valid_q <= if_valid_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
`ifdef FETCH_CTRL_MISALIGN_EN
            fault_q    <= fault_d;
`endif
        end
    end

    assign imem_req = imem_req_q;
    assign if_valid = if_valid_q;
    assign if_pc    = if_pc_q;
    assign if_instr = if_instr_q;
`ifdef FETCH_CTRL_MISALIGN_EN
    assign imem_addr   = req_addr_q;
    assign fetch_fault = fault_q;
`else
    assign imem_addr   = {req_addr_q[XLEN-1:2], 2'b00};
    assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: models the pc register and drives imem/decode handshakes cycle by cycle.
`timescale 1ns/1ps
module tb_fetch_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        pc_pause;
    logic [31:0] pc_npc;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_ready;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        fetch_fault;

    int checks   = 0;
    int failures = 0;

    fetch_ctrl dut (
        .clock       (clock),
        .reset       (reset),
        .pc          (pc),
        .pc_pause    (pc_pause),
        .pc_npc      (pc_npc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .id_ready    (id_ready),
        .if_valid    (if_valid),
        .if_pc       (if_pc),
        .if_instr    (if_instr),
        .fetch_fault (fetch_fault)
    );

    always #5 clock = ~clock;

    // Reference pc register driven by the DUT's pause/npc.
    always @(posedge clock) begin
        if (reset) pc <= 32'h0;
        else if (!pc_pause) pc <= pc_npc;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Zero-wait fetch starting in a REQ cycle; returns in the HOLD cycle.
    task automatic do_fetch(input logic [31:0] addr, input logic [31:0] exp_if_pc,
                            input logic [31:0] data, input string tag);
        check({tag, "_req"}, imem_req, 32'd1);
        check({tag, "_addr"}, imem_addr, addr);
        imem_ack = 1'b1;
        #1;
        check({tag, "_ack_pause"}, pc_pause, 32'd0);
        check({tag, "_ack_npc"}, pc_npc, pc + 32'd4);
        step();
        imem_ack = 1'b0;
        check({tag, "_wait_req"}, imem_req, 32'd0);
        check({tag, "_wait_valid"}, if_valid, 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        step();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        check({tag, "_valid"}, if_valid, 32'd1);
        check({tag, "_if_pc"}, if_pc, exp_if_pc);
        check({tag, "_instr"}, if_instr, data);
        check({tag, "_hold_pause"}, pc_pause, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        imem_ack    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        id_ready    = 1'b1;
        repeat (3) step();
        check("rst_req", imem_req, 32'd0);
        check("rst_valid", if_valid, 32'd0);
        check("rst_if_pc", if_pc, 32'h0);
        check("rst_instr", if_instr, 32'h0);
        check("rst_fault", fetch_fault, 32'd0);
        check("rst_pause", pc_pause, 32'd1);

        reset = 1'b0;
        check("idle_req", imem_req, 32'd0);
        step();

        // Back-to-back zero-wait fetches 0x0, 0x4.
        do_fetch(32'h0, 32'h0, 32'h0000_0013, "f0");
        step();
        do_fetch(32'h4, 32'h4, 32'h0040_0093, "f4");

        // Decode stalls for five cycles in HOLD.
        id_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", if_valid, 32'd1);
            check("stall_instr", if_instr, 32'h0040_0093);
            check("stall_req", imem_req, 32'd0);
            check("stall_pause", pc_pause, 32'd1);
            step();
        end
        id_ready = 1'b1;
        step();

        // Redirect to 0x200 on the same cycle as the ack for 0x8.
        check("r8_req", imem_req, 32'd1);
        check("r8_addr", imem_addr, 32'h8);
        imem_ack    = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        #1;
        check("r8_pause", pc_pause, 32'd0);
        check("r8_npc", pc_npc, 32'h200);
        step();
        imem_ack = 1'b0;
        redirect = 1'b0;
        check("r8_pc", pc, 32'h200);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_0008;
        step();
        imem_rvalid = 1'b0;
        check("r8_drop_valid", if_valid, 32'd0);
        check("r8_drop_req", imem_req, 32'd0);
        step();
        do_fetch(32'h200, 32'h200, 32'h0010_0113, "f200");
        step();

        // Redirect to 0x100 while waiting; the response arrives three cycles later.
        check("w_req", imem_req, 32'd1);
        check("w_addr", imem_addr, 32'h204);
        imem_ack = 1'b1;
        step();
        imem_ack    = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        #1;
        check("w_pause", pc_pause, 32'd0);
        check("w_npc", pc_npc, 32'h100);
        step();
        redirect = 1'b0;
        check("w_kill_req", imem_req, 32'd0);
        step();
        step();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        step();
        imem_rvalid = 1'b0;
        check("w_drop_valid", if_valid, 32'd0);
        check("w_drop_req", imem_req, 32'd0);
        step();
        do_fetch(32'h100, 32'h100, 32'h0020_0193, "f100");

        // Redirect from HOLD to the misaligned target 0x102.
        redirect    = 1'b1;
        redirect_pc = 32'h102;
        step();
        redirect = 1'b0;
        check("h_valid", if_valid, 32'd0);
        check("h_req", imem_req, 32'd0);
        step();
`ifdef FETCH_CTRL_MISALIGN_EN
        for (int i = 0; i < 3; i++) begin
            check("mf_fault", fetch_fault, 32'd1);
            check("mf_if_pc", if_pc, 32'h102);
            check("mf_valid", if_valid, 32'd0);
            check("mf_req", imem_req, 32'd0);
            check("mf_pause", pc_pause, 32'd1);
            step();
        end
        redirect    = 1'b1;
        redirect_pc = 32'h104;
        step();
        redirect = 1'b0;
        check("mf_clear", fetch_fault, 32'd0);
        check("mf_clear_req", imem_req, 32'd0);
        step();
        do_fetch(32'h104, 32'h104, 32'h0030_0213, "f104");
`else
        check("ma_fault", fetch_fault, 32'd0);
        do_fetch(32'h100, 32'h102, 32'h0030_0213, "f102");
        check("ma_fault_hold", fetch_fault, 32'd0);
`endif

        // Reset in WAIT; the late response must be ignored.
        step();
        check("mr_req", imem_req, 32'd1);
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        reset    = 1'b1;
        step();
        reset = 1'b0;
        check("mr_rst_req", imem_req, 32'd0);
        check("mr_rst_valid", if_valid, 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h1234_5678;
        step();
        imem_rvalid = 1'b0;
        check("mr_late_valid", if_valid, 32'd0);
        check("mr_late_req", imem_req, 32'd1);
        check("mr_late_addr", imem_addr, 32'h0);
        step();
        check("mr_still_req", imem_req, 32'd1);
        check("mr_still_valid", if_valid, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
